// File: rtl/qsgmii_rx_aggregator.sv
// Packet-granular round-robin merge of four per-lane AXI-Stream RX streams, tagging each frame with its lane.
// Optional per-lane frame/abort counters are enabled with `define QSGMII_AGG_STATS_EN.
module qsgmii_rx_aggregator #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              link_up,
  input  logic [NUM_PORTS-1:0]              s_tvalid,
  output logic [NUM_PORTS-1:0]              s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]              s_tlast,
  input  logic [NUM_PORTS-1:0]              s_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_tkeep,
  output logic                              m_tlast,
  output logic                              m_tuser,
  output logic [1:0]                        m_tdest
`ifdef QSGMII_AGG_STATS_EN
  ,
  input  logic                              stats_clear,
  output logic [NUM_PORTS*32-1:0]           stats_frames,
  output logic [NUM_PORTS*16-1:0]           stats_aborts
`endif
);

  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [1:0]             grant_r, grant_s;
  logic [1:0]             rr_ptr_r, rr_ptr_s;
  logic [NUM_PORTS-1:0]   flush_r, flush_s;
  logic [NUM_PORTS-1:0]   link_d_r;
  logic [NUM_PORTS-1:0]   eligible_s;
  logic [1:0]             pick_s;
  logic [1:0]             idx_s;
  logic                   pick_valid_s;
  logic                   last_hs_s;
  logic                   abort_hs_s;

  assign eligible_s = s_tvalid & link_up & ~flush_r;

  // Round-robin search: iterate farthest-first so the lane nearest rr_ptr overwrites the pick.
  always_comb begin
    pick_s       = rr_ptr_r;
    pick_valid_s = 1'b0;
    idx_s        = rr_ptr_r;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx_s = rr_ptr_r + 2'(i);
      if (eligible_s[idx_s]) begin
        pick_s       = idx_s;
        pick_valid_s = 1'b1;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Next-state and stream muxing; draining lanes accept in every state.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    rr_ptr_s   = rr_ptr_r;
    s_tready   = flush_r;
    m_tvalid   = 1'b0;
    m_tdata    = {DATA_WIDTH{1'b0}};
    m_tkeep    = {KW{1'b0}};
    m_tlast    = 1'b0;
    m_tuser    = 1'b0;
    m_tdest    = 2'd0;
    last_hs_s  = 1'b0;
    abort_hs_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          grant_s = pick_s;
          state_s = XFER;
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        m_tvalid          = s_tvalid[grant_r];
        m_tdata           = s_tdata[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep           = s_tkeep[int'(grant_r)*KW +: KW];
        m_tlast           = s_tlast[grant_r];
        m_tuser           = s_tuser[grant_r];
        m_tdest           = grant_r;
        s_tready[grant_r] = m_tready;
        last_hs_s         = m_tready & s_tvalid[grant_r] & s_tlast[grant_r];
        // A tlast accepted while the link falls still completes the frame normally.
        if (last_hs_s) begin
          rr_ptr_s = grant_r + 2'd1;
          state_s  = IDLE;
        end else if (!link_up[grant_r]) begin
          state_s = ABORT;
        end else begin
          state_s = XFER;
        end
      end
      ABORT: begin
        m_tvalid          = 1'b1;
        m_tlast           = 1'b1;
        m_tuser           = 1'b1;
        m_tdest           = grant_r;
        s_tready[grant_r] = 1'b0;
        abort_hs_s        = m_tready;
        if (m_tready) begin
          rr_ptr_s = grant_r + 2'd1;
          state_s  = IDLE;
        end else begin
          state_s = ABORT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Flush bookkeeping: cleared by the discarded tlast or a link recovery, set by an abort handshake.
  always_comb begin
    flush_s = flush_r;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if ((flush_r[p] && s_tvalid[p] && s_tlast[p]) || (link_up[p] && !link_d_r[p])) begin
        flush_s[p] = 1'b0;
      end else begin
        flush_s[p] = flush_r[p];
      end
    end
    flush_s[grant_r] = flush_s[grant_r] | abort_hs_s;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      grant_r  <= 2'd0;
      rr_ptr_r <= 2'd0;
      flush_r  <= {NUM_PORTS{1'b0}};
      link_d_r <= {NUM_PORTS{1'b0}};
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      rr_ptr_r <= rr_ptr_s;
      flush_r  <= flush_s;
      link_d_r <= link_up;
    end
  end

`ifdef QSGMII_AGG_STATS_EN
  logic [NUM_PORTS-1:0][31:0] frames_r;
  logic [NUM_PORTS-1:0][15:0] aborts_r;
  logic                       good_last_s;

  assign good_last_s = last_hs_s & ~s_tuser[grant_r];

  // Saturating per-lane counters; a clear overrides a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_r <= '0;
      aborts_r <= '0;
    end else if (stats_clear) begin
      frames_r <= '0;
      aborts_r <= '0;
    end else begin
      if (good_last_s && (frames_r[grant_r] != 32'hFFFF_FFFF)) begin
        frames_r[grant_r] <= frames_r[grant_r] + 32'd1;
      end
      if (abort_hs_s && (aborts_r[grant_r] != 16'hFFFF)) begin
        aborts_r[grant_r] <= aborts_r[grant_r] + 16'd1;
      end
    end
  end

  assign stats_frames = frames_r;
  assign stats_aborts = aborts_r;
`endif

endmodule
